ctrl_unit_mc: RTL and testbench

CTRL_UNIT_MC -- requirements
Module: ctrl_unit_mc

---
 rtl/ctrl_pkg.sv | 82 ++++++++
 rtl/mem_wait_ctr.sv | 30 +++
 rtl/ctrl_unit_mc.sv | 239 +++++++++++++++++++++++
 tb/tb_ctrl_unit_mc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes,
// functs, ALU operations and every datapath mux-select code.
package ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ASRC_W  = 2;
  localparam int unsigned BSRC_W  = 2;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned MTR_W   = 4;
  localparam int unsigned PCSRC_W = 3;
  localparam int unsigned IORD_W  = 3;
  localparam int unsigned RDST_W  = 2;
  localparam int unsigned ESEL_W  = 2;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_ALU   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_EXC      = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_RST   = 6'h3F;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'd3;

  localparam logic [ASRC_W-1:0] ASRC_PC = 2'd0;
  localparam logic [ASRC_W-1:0] ASRC_A  = 2'd1;

  localparam logic [BSRC_W-1:0] BSRC_B     = 2'd0;
  localparam logic [BSRC_W-1:0] BSRC_4     = 2'd1;
  localparam logic [BSRC_W-1:0] BSRC_SEXT  = 2'd2;
  localparam logic [BSRC_W-1:0] BSRC_SHIFT = 2'd3;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 3'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 3'd2;
  localparam logic [PCSRC_W-1:0] PCSRC_VEC    = 3'd3;

  localparam logic [IORD_W-1:0] IORD_PC     = 3'd0;
  localparam logic [IORD_W-1:0] IORD_ALUOUT = 3'd1;
  localparam logic [IORD_W-1:0] IORD_VEC    = 3'd2;

  localparam logic [MTR_W-1:0] MTR_ALU = 4'b0000;
  localparam logic [MTR_W-1:0] MTR_MDR = 4'b0001;
  localparam logic [MTR_W-1:0] MTR_SP  = 4'b1000;

  localparam logic [RDST_W-1:0] RDST_RT  = 2'd0;
  localparam logic [RDST_W-1:0] RDST_RD  = 2'd1;
  localparam logic [RDST_W-1:0] RDST_R29 = 2'd3;

  localparam logic [ESEL_W-1:0] ESEL_UNDEF = 2'd0;
  localparam logic [ESEL_W-1:0] ESEL_OVF   = 2'd1;

  // Exception vector byte address select: one slot per cause after IORD_VEC
  function automatic logic [IORD_W-1:0] iord_vec(input logic [ESEL_W-1:0] sel);
    return IORD_VEC + IORD_W'(sel);
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Saturating wait counter: cleared on state entry, counts while the FSM
// stays put, flags when it reaches the requested target.
module mem_wait_ctr
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_count,
  input  logic [CNT_W-1:0] i_target,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_count && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == i_target);

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multi-cycle MIPS-style control unit: Moore FSM sequencing fetch, decode,
// execute, memory, branch/jump and exception handling.
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned OVF_TRAP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode,
  input  logic [OP_W-1:0]     funct,
  input  logic                overflow,
  input  logic                zero,
  output logic                pc_write,
  output logic                mem_write,
  output logic                ir_write,
  output logic                ab_write,
  output logic                alu_out_write,
  output logic                reg_write,
  output logic                epc_write,
  output logic [ASRC_W-1:0]   alu_src_a,
  output logic [BSRC_W-1:0]   alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [MTR_W-1:0]    mem_to_reg,
  output logic [PCSRC_W-1:0]  pc_source,
  output logic [IORD_W-1:0]   iord,
  output logic [RDST_W-1:0]   reg_dst,
  output logic [ESEL_W-1:0]   exception_sel
);

  localparam bit TRAP_EN = (OVF_TRAP != 0);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ESEL_W-1:0]   r_exc_sel;
  logic [ESEL_W-1:0]   w_exc_sel_nxt;
  logic                w_load;
  logic                w_count;
  logic                w_done;
  logic [CNT_W-1:0]    w_cnt;
  logic [CNT_W-1:0]    w_target;
  logic                w_arith;
  logic                w_bad_fn;

  // EXC spends one extra cycle on EPC before the vector read
  assign w_target = (r_state == ST_EXC) ? CNT_W'(MEM_WAIT) : CNT_W'(MEM_WAIT - 1);
  assign w_load   = (w_state_nxt != r_state);
  assign w_count  = ~w_load;

  mem_wait_ctr u_wait (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_count  (w_count),
    .i_target (w_target),
    .o_cnt    (w_cnt),
    .o_done   (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RESET;
      r_exc_sel <= ESEL_UNDEF;
    end else begin
      r_state   <= w_state_nxt;
      r_exc_sel <= w_exc_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_exc_sel_nxt = r_exc_sel;
    w_arith       = 1'b0;
    w_bad_fn      = 1'b0;
    pc_write      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    ab_write      = 1'b0;
    alu_out_write = 1'b0;
    reg_write     = 1'b0;
    epc_write     = 1'b0;
    alu_src_a     = ASRC_PC;
    alu_src_b     = BSRC_B;
    alu_op        = '0;
    mem_to_reg    = MTR_ALU;
    pc_source     = PCSRC_ALU;
    iord          = IORD_PC;
    reg_dst       = RDST_RT;
    exception_sel = ESEL_UNDEF;

    unique case (r_state)
      ST_RESET: begin
        reg_write   = 1'b1;
        mem_to_reg  = MTR_SP;
        reg_dst     = RDST_R29;
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        iord      = IORD_PC;
        alu_src_a = ASRC_PC;
        alu_src_b = BSRC_4;
        alu_op    = ALU_ADD;
        if (w_done) begin
          pc_write    = 1'b1;
          pc_source   = PCSRC_ALU;
          ir_write    = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ab_write      = 1'b1;
        alu_out_write = 1'b1;
        alu_src_a     = ASRC_PC;
        alu_src_b     = BSRC_SHIFT;
        alu_op        = ALU_ADD;
        case (opcode)
          OP_RTYPE:      w_state_nxt = ST_EXEC_R;
          OP_ADDI:       w_state_nxt = ST_EXEC_I;
          OP_LW, OP_SW:  w_state_nxt = ST_MEM_ADDR;
          OP_BEQ, OP_BNE: w_state_nxt = ST_BRANCH;
          OP_J:          w_state_nxt = ST_JUMP;
          OP_RST:        w_state_nxt = ST_RESET;
          default: begin
            w_state_nxt   = ST_EXC;
            w_exc_sel_nxt = ESEL_UNDEF;
          end
        endcase
      end

      ST_EXEC_R: begin
        alu_src_a = ASRC_A;
        alu_src_b = BSRC_B;
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; w_arith = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; w_arith = 1'b1; end
          FN_AND: alu_op = ALU_AND;
          default: w_bad_fn = 1'b1;
        endcase
        if (w_bad_fn) begin
          w_state_nxt   = ST_EXC;
          w_exc_sel_nxt = ESEL_UNDEF;
        end else if (w_arith && overflow && TRAP_EN) begin
          w_state_nxt   = ST_EXC;
          w_exc_sel_nxt = ESEL_OVF;
        end else begin
          alu_out_write = 1'b1;
          w_state_nxt   = ST_WB_ALU;
        end
      end

      ST_EXEC_I: begin
        alu_src_a = ASRC_A;
        alu_src_b = BSRC_SEXT;
        alu_op    = ALU_ADD;
        if (overflow && TRAP_EN) begin
          w_state_nxt   = ST_EXC;
          w_exc_sel_nxt = ESEL_OVF;
        end else begin
          alu_out_write = 1'b1;
          w_state_nxt   = ST_WB_ALU;
        end
      end

      ST_WB_ALU: begin
        reg_write   = 1'b1;
        mem_to_reg  = MTR_ALU;
        reg_dst     = (opcode == OP_RTYPE) ? RDST_RD : RDST_RT;
        w_state_nxt = ST_FETCH;
      end

      ST_MEM_ADDR: begin
        alu_src_a     = ASRC_A;
        alu_src_b     = BSRC_SEXT;
        alu_op        = ALU_ADD;
        alu_out_write = 1'b1;
        w_state_nxt   = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end

      ST_MEM_RD: begin
        iord = IORD_ALUOUT;
        if (w_done) w_state_nxt = ST_MEM_WB;
      end

      ST_MEM_WB: begin
        reg_write   = 1'b1;
        mem_to_reg  = MTR_MDR;
        reg_dst     = RDST_RT;
        w_state_nxt = ST_FETCH;
      end

      ST_MEM_WR: begin
        mem_write   = 1'b1;
        iord        = IORD_ALUOUT;
        w_state_nxt = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_src_a = ASRC_A;
        alu_src_b = BSRC_B;
        alu_op    = ALU_SUB;
        if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero)) begin
          pc_write  = 1'b1;
          pc_source = PCSRC_ALUOUT;
        end
        w_state_nxt = ST_FETCH;
      end

      ST_JUMP: begin
        pc_write    = 1'b1;
        pc_source   = PCSRC_JUMP;
        w_state_nxt = ST_FETCH;
      end

      // Counter 0 saves EPC = PC-4; remaining cycles read the vector
      ST_EXC: begin
        exception_sel = r_exc_sel;
        if (w_cnt == '0) begin
          epc_write = 1'b1;
          alu_src_a = ASRC_PC;
          alu_src_b = BSRC_4;
          alu_op    = ALU_SUB;
        end else begin
          iord = iord_vec(r_exc_sel);
          if (w_done) begin
            pc_write    = 1'b1;
            pc_source   = PCSRC_VEC;
            w_state_nxt = ST_FETCH;
          end
        end
      end

      default: w_state_nxt = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Directed bench for ctrl_unit_mc: instruction table on a MEM_WAIT=1 trapping
// instance, hand sequences on a MEM_WAIT=3 non-trapping instance.
module tb_ctrl_unit_mc;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst3;
  logic [5:0] op1, fn1, op3, fn3;
  logic       ovf1, z1, ovf3, z3;

  logic       d1_pcw, d1_mw, d1_irw, d1_abw, d1_aow, d1_rw, d1_epc;
  logic [1:0] d1_asa, d1_asb, d1_rdst, d1_esel;
  logic [2:0] d1_aop, d1_pcs, d1_iord;
  logic [3:0] d1_mtr;
  logic       d3_pcw, d3_mw, d3_irw, d3_abw, d3_aow, d3_rw, d3_epc;
  logic [1:0] d3_asa, d3_asb, d3_rdst, d3_esel;
  logic [2:0] d3_aop, d3_pcs, d3_iord;
  logic [3:0] d3_mtr;

  ctrl_unit_mc #(.MEM_WAIT(1), .OVF_TRAP(1)) u_dut1 (
    .clk(clk), .reset(rst1), .opcode(op1), .funct(fn1), .overflow(ovf1), .zero(z1),
    .pc_write(d1_pcw), .mem_write(d1_mw), .ir_write(d1_irw), .ab_write(d1_abw),
    .alu_out_write(d1_aow), .reg_write(d1_rw), .epc_write(d1_epc),
    .alu_src_a(d1_asa), .alu_src_b(d1_asb), .alu_op(d1_aop), .mem_to_reg(d1_mtr),
    .pc_source(d1_pcs), .iord(d1_iord), .reg_dst(d1_rdst), .exception_sel(d1_esel)
  );

  ctrl_unit_mc #(.MEM_WAIT(3), .OVF_TRAP(0)) u_dut3 (
    .clk(clk), .reset(rst3), .opcode(op3), .funct(fn3), .overflow(ovf3), .zero(z3),
    .pc_write(d3_pcw), .mem_write(d3_mw), .ir_write(d3_irw), .ab_write(d3_abw),
    .alu_out_write(d3_aow), .reg_write(d3_rw), .epc_write(d3_epc),
    .alu_src_a(d3_asa), .alu_src_b(d3_asb), .alu_op(d3_aop), .mem_to_reg(d3_mtr),
    .pc_source(d3_pcs), .iord(d3_iord), .reg_dst(d3_rdst), .exception_sel(d3_esel)
  );

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       ovf;
    logic       z;
    int cyc; int rw; int pcw; int epc; int mw; int esel;
    int pcsrc; int piord; int rdst; int mtr;
  } vec_t;

  vec_t vecs[18];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observe dut1 from the cycle after an ir_write up to the next ir_write
  task automatic run1(output int cyc, output int rw, output int pcw, output int epc,
                      output int mw, output int esel, output int pcsrc, output int piord,
                      output int rdst, output int mtr, output int aop, output int asb,
                      output bit to);
    cyc = 0; rw = 0; pcw = 0; epc = 0; mw = 0; esel = 0;
    pcsrc = -1; piord = -1; rdst = -1; mtr = -1; aop = -1; asb = -1; to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d1_irw) begin
        to = 1'b0;
        break;
      end
      cyc++;
      if (d1_rw)  begin rw++;  rdst = int'(d1_rdst); mtr = int'(d1_mtr); end
      if (d1_pcw) begin pcw++; pcsrc = int'(d1_pcs); piord = int'(d1_iord); end
      if (d1_epc) begin epc++; aop = int'(d1_aop); asb = int'(d1_asb); end
      if (d1_mw)  mw++;
      esel = esel | int'(d1_esel);
    end
  endtask

  // Observe dut3 for n cycles, recording first-occurrence cycle indices
  task automatic run3(input int n, output int first_ir, output int first_pcw,
                      output int first_rw, output int rw_cnt, output int iord1_cnt,
                      output int epc_cnt, output int aow_cnt, output int mtr, output int rdst);
    first_ir = 0; first_pcw = 0; first_rw = 0; rw_cnt = 0; iord1_cnt = 0;
    epc_cnt = 0; aow_cnt = 0; mtr = -1; rdst = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (d3_irw && first_ir == 0)  first_ir = k;
      if (d3_pcw && first_pcw == 0) first_pcw = k;
      if (d3_rw) begin
        rw_cnt++;
        if (first_rw == 0) begin first_rw = k; mtr = int'(d3_mtr); rdst = int'(d3_rdst); end
      end
      if (d3_iord == 3'd1) iord1_cnt++;
      if (d3_epc) epc_cnt++;
      if (d3_aow) aow_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, rw, pcw, epc, mw, esel, pcsrc, piord, rdst, mtr, aop, asb;
    int fir, fpw, frw, rwc, i1c, epcc, aowc;
    bit to;

    //            op     fn     ovf   z     cyc rw pcw epc mw esel pcs iord rdst mtr
    vecs[0]  = '{6'h00, 6'h20, 1'b0, 1'b0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 1'b1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{6'h00, 6'h24, 1'b1, 1'b0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[3]  = '{6'h00, 6'h20, 1'b1, 1'b0, 4, 0, 1, 1, 0, 1, 3, 3, 0, 0};
    vecs[4]  = '{6'h00, 6'h22, 1'b1, 1'b0, 4, 0, 1, 1, 0, 1, 3, 3, 0, 0};
    vecs[5]  = '{6'h00, 6'h25, 1'b0, 1'b0, 4, 0, 1, 1, 0, 0, 3, 2, 0, 0};
    vecs[6]  = '{6'h08, 6'h00, 1'b0, 1'b0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{6'h08, 6'h00, 1'b1, 1'b0, 4, 0, 1, 1, 0, 1, 3, 3, 0, 0};
    vecs[8]  = '{6'h23, 6'h00, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{6'h2B, 6'h00, 1'b0, 1'b0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{6'h04, 6'h00, 1'b0, 1'b1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[11] = '{6'h04, 6'h00, 1'b0, 1'b0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{6'h05, 6'h00, 1'b0, 1'b0, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[13] = '{6'h05, 6'h00, 1'b0, 1'b1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{6'h02, 6'h00, 1'b0, 1'b0, 2, 0, 1, 0, 0, 0, 2, 0, 0, 0};
    vecs[15] = '{6'h3F, 6'h00, 1'b0, 1'b0, 2, 1, 0, 0, 0, 0, 0, 0, 3, 8};
    vecs[16] = '{6'h11, 6'h00, 1'b0, 1'b0, 3, 0, 1, 1, 0, 0, 3, 2, 0, 0};
    vecs[17] = '{6'h23, 6'h00, 1'b1, 1'b1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1};

    rst1 = 1'b1; rst3 = 1'b1;
    op1 = 6'h02; fn1 = 6'h00; ovf1 = 1'b0; z1 = 1'b0;
    op3 = 6'h23; fn3 = 6'h00; ovf3 = 1'b0; z3 = 1'b0;

    // Reset held: RESET outputs persist across edges
    repeat (2) @(negedge clk);
    check("rst_reg_write", int'(d1_rw), 1);
    check("rst_mem_to_reg", int'(d1_mtr), 8);
    check("rst_reg_dst", int'(d1_rdst), 3);
    check("rst_pc_write", int'(d1_pcw), 0);
    @(negedge clk);
    check("rst_hold_reg_write", int'(d1_rw), 1);
    rst1 = 1'b0;

    // First edge after release: single-cycle FETCH
    @(negedge clk);
    check("fetch_pc_write", int'(d1_pcw), 1);
    check("fetch_ir_write", int'(d1_irw), 1);
    check("fetch_iord", int'(d1_iord), 0);
    check("fetch_alu_src_b", int'(d1_asb), 1);
    check("fetch_alu_op", int'(d1_aop), int'(ALU_ADD));
    @(negedge clk);
    check("decode_ab_write", int'(d1_abw), 1);
    check("decode_alu_src_b", int'(d1_asb), 3);
    check("decode_pc_write", int'(d1_pcw), 0);
    check("decode_ir_write", int'(d1_irw), 0);
    @(negedge clk);
    check("jump_pc_write", int'(d1_pcw), 1);
    check("jump_pc_source", int'(d1_pcs), 2);
    @(negedge clk);
    check("jump_then_fetch", int'(d1_irw), 1);

    for (int i = 0; i < 18; i++) begin
      op1 = vecs[i].op; fn1 = vecs[i].fn; ovf1 = vecs[i].ovf; z1 = vecs[i].z;
      run1(cyc, rw, pcw, epc, mw, esel, pcsrc, piord, rdst, mtr, aop, asb, to);
      check($sformatf("vec%0d timeout", i), int'(to), 0);
      check($sformatf("vec%0d cycles", i), cyc, vecs[i].cyc);
      check($sformatf("vec%0d reg_write", i), rw, vecs[i].rw);
      check($sformatf("vec%0d pc_write", i), pcw, vecs[i].pcw);
      check($sformatf("vec%0d epc_write", i), epc, vecs[i].epc);
      check($sformatf("vec%0d mem_write", i), mw, vecs[i].mw);
      check($sformatf("vec%0d exception_sel", i), esel, vecs[i].esel);
      if (vecs[i].pcw > 0) begin
        check($sformatf("vec%0d pc_source", i), pcsrc, vecs[i].pcsrc);
        check($sformatf("vec%0d iord_at_pcw", i), piord, vecs[i].piord);
      end
      if (vecs[i].rw > 0) begin
        check($sformatf("vec%0d reg_dst", i), rdst, vecs[i].rdst);
        check($sformatf("vec%0d mem_to_reg", i), mtr, vecs[i].mtr);
      end
      if (vecs[i].epc > 0) begin
        check($sformatf("vec%0d epc_alu_op", i), aop, int'(ALU_SUB));
        check($sformatf("vec%0d epc_alu_src_b", i), asb, 1);
      end
    end

    // MEM_WAIT=3 load: 3 FETCH, DECODE, MEM_ADDR, 3 MEM_RD, MEM_WB
    rst3 = 1'b0;
    run3(9, fir, fpw, frw, rwc, i1c, epcc, aowc, mtr, rdst);
    check("lw3_first_ir", fir, 3);
    check("lw3_first_pcw", fpw, 3);
    check("lw3_writeback_cycle", frw, 9);
    check("lw3_rw_count", rwc, 1);
    check("lw3_mem_rd_cycles", i1c, 3);
    check("lw3_mem_to_reg", mtr, 1);
    check("lw3_reg_dst", rdst, 0);
    @(negedge clk);
    check("lw3_next_fetch_pcw", int'(d3_pcw), 0);
    check("lw3_next_fetch_iord", int'(d3_iord), 0);

    // Overflow ignored when trapping is disabled
    rst3 = 1'b1;
    op3 = 6'h00; fn3 = 6'h20; ovf3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    run3(7, fir, fpw, frw, rwc, i1c, epcc, aowc, mtr, rdst);
    check("novf_first_ir", fir, 3);
    check("novf_epc", epcc, 0);
    check("novf_writeback_cycle", frw, 6);
    check("novf_reg_dst", rdst, 1);
    check("novf_mem_to_reg", mtr, 0);
    check("novf_alu_out_write", aowc, 2);

    // Reset pulse in the middle of MEM_RD abandons the load
    rst3 = 1'b1;
    op3 = 6'h23; fn3 = 6'h00; ovf3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    run3(6, fir, fpw, frw, rwc, i1c, epcc, aowc, mtr, rdst);
    check("midrst_in_mem_rd", i1c, 1);
    check("midrst_no_rw_before", rwc, 0);
    rst3 = 1'b1;
    #1;
    check("midrst_async_mtr", int'(d3_mtr), 8);
    check("midrst_async_reg_dst", int'(d3_rdst), 3);
    check("midrst_async_iord", int'(d3_iord), 0);
    @(negedge clk);
    check("midrst_hold_mtr", int'(d3_mtr), 8);
    rst3 = 1'b0;
    run3(4, fir, fpw, frw, rwc, i1c, epcc, aowc, mtr, rdst);
    check("midrst_refetch_ir", fir, 3);
    check("midrst_no_writeback", rwc, 0);
    check("midrst_no_mem_rd", i1c, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
